// File: rtl/mem_port_arbiter.sv
// Shares one external bus port between instruction fetch (IF) and data access (MEM).
// Optional bus-hang watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic [DW-1:0]   if_rdata,
   output logic            if_ready,
   input  logic            mem_req,
   input  logic            mem_we,
   input  logic [AW-1:0]   mem_addr,
   input  logic [DW-1:0]   mem_wdata,
   input  logic [DW/8-1:0] mem_sel,
   output logic [DW-1:0]   mem_rdata,
   output logic            mem_ready,
   output logic            bus_req,
   output logic            bus_we,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   output logic [DW/8-1:0] bus_sel,
   input  logic            bus_ack,
   input  logic [DW-1:0]   bus_rdata,
   output logic            bus_err,
   output logic            stallreq_if,
   output logic            stallreq_mem
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GNT_IF  = 2'd1,
      S_GNT_MEM = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            bus_req_q, bus_req_d;
   logic            bus_we_q, bus_we_d;
   logic [AW-1:0]   bus_addr_q, bus_addr_d;
   logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
   logic [DW/8-1:0] bus_sel_q, bus_sel_d;
   logic [DW-1:0]   if_rdata_q, if_rdata_d;
   logic [DW-1:0]   mem_rdata_q, mem_rdata_d;
   logic            if_ready_q, if_ready_d;
   logic            mem_ready_q, mem_ready_d;
   logic            mem_grant_s, if_grant_s;

`ifdef ARB_TIMEOUT_EN
   localparam int CW_RAW = $clog2(TIMEOUT + 1);
   localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;
   localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
   logic          bus_err_q, bus_err_d;

   assign cnt_inc_s = cnt_q + {{(CW-1){1'b0}}, 1'b1};
   assign bus_err   = bus_err_q;
`else
   assign bus_err   = 1'b0;
`endif

   // A requester whose ready is pulsing this cycle is locked out, so the other side gets a turn.
   assign mem_grant_s = mem_req & ~mem_ready_q;
   assign if_grant_s  = if_req & ~if_ready_q;

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_sel_d   = bus_sel_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
      bus_err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (mem_grant_s) begin
               state_d     = S_GNT_MEM;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_we;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
               bus_sel_d   = mem_sel;
`ifdef ARB_TIMEOUT_EN
               cnt_d       = {CW{1'b0}};
`endif
            end else if (if_grant_s) begin
               state_d     = S_GNT_IF;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = if_addr;
               bus_wdata_d = {DW{1'b0}};
               bus_sel_d   = {(DW/8){1'b1}};
`ifdef ARB_TIMEOUT_EN
               cnt_d       = {CW{1'b0}};
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GNT_IF, S_GNT_MEM: begin
            if (bus_ack) begin
               state_d   = S_IDLE;
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               if (state_q == S_GNT_IF) begin
                  if_rdata_d = bus_rdata;
                  if_ready_d = 1'b1;
               end else begin
                  mem_rdata_d = bus_rdata;
                  mem_ready_d = 1'b1;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_inc_s == TO_CNT) begin
               state_d   = S_IDLE;
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               bus_err_d = 1'b1;
               if (state_q == S_GNT_IF) begin
                  if_rdata_d = {DW{1'b0}};
                  if_ready_d = 1'b1;
               end else begin
                  mem_rdata_d = {DW{1'b0}};
                  mem_ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_inc_s;
            end
`else
            else begin
               state_d = state_q;
            end
`endif
         end
         default: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
            bus_we_d  = 1'b0;
         end
      endcase
   end

   // State and bus-side registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= {AW{1'b0}};
         bus_wdata_q <= {DW{1'b0}};
         bus_sel_q   <= {(DW/8){1'b0}};
         if_rdata_q  <= {DW{1'b0}};
         mem_rdata_q <= {DW{1'b0}};
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= {CW{1'b0}};
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_sel_q   <= bus_sel_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_sel   = bus_sel_q;
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_ready  = if_ready_q;
   assign mem_ready = mem_ready_q;

   assign stallreq_if  = rst & if_req & ~if_ready_q;
   assign stallreq_mem = rst & mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected bus transactions and ready pulses are queued
// by the stimulus and consumed by independent monitors.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic          clk, rst;
   logic          if_req, if_ready, mem_req, mem_we, mem_ready;
   logic [AW-1:0] if_addr, mem_addr, bus_addr;
   logic [DW-1:0] if_rdata, mem_rdata, mem_wdata, bus_wdata, bus_rdata;
   logic [3:0]    mem_sel, bus_sel;
   logic          bus_req, bus_we, bus_ack, bus_err, stallreq_if, stallreq_mem;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { bit is_mem; bit chk; logic [31:0] data; bit err; } rsp_t;
   typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] sel; } bus_t;

   rsp_t rsp_q[$];
   bus_t bus_q[$];
   int   total = 0;
   int   bad   = 0;
   int   bus_wait = 0;
   int   stray_pulse = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rdata_for(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h0050_0093;
         32'h0000_0104: return 32'h0010_0113;
         default:       return a ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   function automatic rsp_t mk_rsp(input bit m, input bit c, input logic [31:0] d, input bit e);
      rsp_t r;
      r.is_mem = m; r.chk = c; r.data = d; r.err = e;
      return r;
   endfunction

   function automatic bus_t mk_bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
      bus_t b;
      b.we = w; b.addr = a; b.wdata = d; b.sel = s;
      return b;
   endfunction

   // Bus slave: acks after bus_wait extra cycles; can also inject a stray ack.
   initial begin
      int cnt = 0;
      int stray_seen = 0;
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (stray_seen != stray_pulse) begin
            stray_seen = stray_pulse;
            bus_ack = 1'b1;
            bus_rdata = 32'hBAD0_BAD0;
         end else if (bus_ack) begin
            bus_ack = 1'b0;
            cnt = 0;
         end else if (bus_req) begin
            if (cnt >= bus_wait) begin
               bus_ack = 1'b1;
               bus_rdata = rdata_for(bus_addr);
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: every ready pulse and every new bus request is matched against the queues.
   initial begin
      logic prev_req = 1'b0;
      rsp_t e;
      bus_t b;
      forever begin
         @(negedge clk);
         if (if_ready || mem_ready) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_ready", {30'h0, if_ready, mem_ready}, 32'h0);
            end else begin
               e = rsp_q.pop_front();
               check("ready_port", {31'h0, mem_ready}, {31'h0, e.is_mem});
               if (e.chk) check("ready_data", mem_ready ? mem_rdata : if_rdata, e.data);
               check("ready_bus_err", {31'h0, bus_err}, {31'h0, e.err});
            end
         end
         if (bus_req && !prev_req) begin
            if (bus_q.size() == 0) begin
               check("unexpected_bus_req", bus_addr, 32'hFFFF_FFFF);
            end else begin
               b = bus_q.pop_front();
               check("bus_we", {31'h0, bus_we}, {31'h0, b.we});
               check("bus_addr", bus_addr, b.addr);
               check("bus_sel", {28'h0, bus_sel}, {28'h0, b.sel});
               if (b.we) check("bus_wdata", bus_wdata, b.wdata);
            end
         end
         prev_req = bus_req;
      end
   end

   task automatic do_if(input logic [31:0] a, output int n);
      bit done = 0;
      if_addr = a;
      if_req = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (if_ready) begin
            done = 1;
            break;
         end
         check("stall_if_wait", {31'h0, stallreq_if}, 32'h1);
      end
      if (!done) check("if_ready_timeout", 32'h0, 32'h1);
      else check("stall_if_ready", {31'h0, stallreq_if}, 32'h0);
      if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_mem(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int n);
      bit done = 0;
      mem_we = w; mem_addr = a; mem_wdata = d; mem_sel = s;
      mem_req = 1'b1;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (mem_ready) begin
            done = 1;
            break;
         end
         check("stall_mem_wait", {31'h0, stallreq_mem}, 32'h1);
      end
      if (!done) check("mem_ready_timeout", 32'h0, 32'h1);
      else check("stall_mem_ready", {31'h0, stallreq_mem}, 32'h0);
      mem_req = 1'b0;
      mem_we = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int n_if, n_mem;
      rst = 1'b0;
      if_req = 1'b1; mem_req = 1'b1;
      if_addr = 32'h0; mem_addr = 32'h0; mem_we = 1'b0; mem_wdata = 32'h0; mem_sel = 4'h0;
      repeat (3) @(negedge clk);
      check("rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_if_ready", {31'h0, if_ready}, 32'h0);
      check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
      check("rst_stall_if", {31'h0, stallreq_if}, 32'h0);
      check("rst_stall_mem", {31'h0, stallreq_mem}, 32'h0);
      if_req = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // IF only, zero-wait bus
      bus_wait = 0;
      bus_q.push_back(mk_bus(1'b0, 32'h100, 32'h0, 4'hF));
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'h0050_0093, 1'b0));
      do_if(32'h100, n_if);
      check("if_latency", n_if, 32'd2);

      // simultaneous requests: MEM write wins, IF granted in the mem_ready cycle
      bus_q.push_back(mk_bus(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF));
      bus_q.push_back(mk_bus(1'b0, 32'h104, 32'h0, 4'hF));
      rsp_q.push_back(mk_rsp(1'b1, 1'b0, 32'h0, 1'b0));
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'h0010_0113, 1'b0));
      fork
         do_mem(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, n_mem);
         do_if(32'h104, n_if);
      join
      check("mem_first_latency", n_mem, 32'd2);
      check("if_after_mem_latency", n_if, 32'd4);

      // three back-to-back loads against a steady fetch stream: strict alternation
      bus_wait = 1;
      bus_q.push_back(mk_bus(1'b0, 32'h1000, 32'h0, 4'hF));
      bus_q.push_back(mk_bus(1'b0, 32'h200, 32'h0, 4'hF));
      bus_q.push_back(mk_bus(1'b0, 32'h1004, 32'h0, 4'hF));
      bus_q.push_back(mk_bus(1'b0, 32'h204, 32'h0, 4'hF));
      bus_q.push_back(mk_bus(1'b0, 32'h1008, 32'h0, 4'hF));
      bus_q.push_back(mk_bus(1'b0, 32'h208, 32'h0, 4'hF));
      rsp_q.push_back(mk_rsp(1'b1, 1'b1, 32'h5A5A_4A5A, 1'b0));
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'h5A5A_585A, 1'b0));
      rsp_q.push_back(mk_rsp(1'b1, 1'b1, 32'h5A5A_4A5E, 1'b0));
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'h5A5A_585E, 1'b0));
      rsp_q.push_back(mk_rsp(1'b1, 1'b1, 32'h5A5A_4A52, 1'b0));
      rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'h5A5A_5852, 1'b0));
      fork
         begin
            int n;
            for (int i = 0; i < 3; i++) do_mem(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'hF, n);
         end
         begin
            int n;
            for (int j = 0; j < 3; j++) do_if(32'h200 + 32'(4 * j), n);
         end
      join
      check("seq_rsp_drained", rsp_q.size(), 32'd0);

      // stray ack in IDLE must change nothing
      stray_pulse++;
      repeat (4) @(negedge clk);
      check("stray_if_rdata", if_rdata, 32'h5A5A_5852);
      check("stray_mem_rdata", mem_rdata, 32'h5A5A_4A52);
      check("stray_bus_req", {31'h0, bus_req}, 32'h0);

`ifdef ARB_TIMEOUT_EN
      // bus never acks: 4 cycles of bus_req, then bus_err with mem_ready and zero data
      begin
         int req_cycles = 0;
         bit done = 0;
         bus_wait = 1000;
         bus_q.push_back(mk_bus(1'b0, 32'h4000, 32'h0, 4'hF));
         rsp_q.push_back(mk_rsp(1'b1, 1'b1, 32'h0, 1'b1));
         mem_we = 1'b0; mem_addr = 32'h4000; mem_sel = 4'hF; mem_req = 1'b1;
         for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_ready) begin
               done = 1;
               break;
            end
            if (bus_req) req_cycles++;
         end
         if (!done) check("timeout_never_ended", 32'h0, 32'h1);
         check("timeout_req_cycles", req_cycles, 32'd4);
         check("timeout_bus_req_dropped", {31'h0, bus_req}, 32'h0);
         mem_req = 1'b0;
         bus_wait = 0;
         repeat (2) @(negedge clk);
      end
`endif

      // reset in the middle of a slow MEM load; the late ack must be ignored
      bus_wait = 5;
      bus_q.push_back(mk_bus(1'b0, 32'h3000, 32'h0, 4'hF));
      mem_we = 1'b0; mem_addr = 32'h3000; mem_sel = 4'hF; mem_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_req) break;
      end
      check("midrst_bus_req_seen", {31'h0, bus_req}, 32'h1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_bus_req", {31'h0, bus_req}, 32'h0);
      check("midrst_bus_addr", bus_addr, 32'h0);
      check("midrst_mem_ready", {31'h0, mem_ready}, 32'h0);
      check("midrst_stall_mem", {31'h0, stallreq_mem}, 32'h0);
      check("midrst_mem_rdata", mem_rdata, 32'h0);
      check("midrst_if_rdata", if_rdata, 32'h0);
      @(negedge clk);
      mem_req = 1'b0;
      rst = 1'b1;
      stray_pulse++;
      repeat (5) @(negedge clk);
      check("midrst_late_ack_rdata", mem_rdata, 32'h0);
      check("midrst_idle_bus_req", {31'h0, bus_req}, 32'h0);

      check("rsp_queue_empty", rsp_q.size(), 32'd0);
      check("bus_queue_empty", bus_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog: a hung run still terminates.
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory/bus port between instruction fetch (IF) and data access (MEM) in the five-stage core.
- Sequences one bus transaction at a time with a req/ack handshake, returning read data to the correct requester.
- Raises stallreq_if / stallreq_mem toward the stall controller while a requester waits.
- Sits between the IF/MEM stages and the bus; registered bus side, combinational stall side.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, cycles bus_req may stay high without bus_ack (optional feature only)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  AW  fetch address, stable while if_req
- if_rdata  out  DW  fetched instruction, valid when if_ready
- if_ready  out  1  one-cycle completion pulse for IF
- mem_req  in  1  data request, held until mem_ready
- mem_we  in  1  1 = write
- mem_addr  in  AW  data address
- mem_wdata  in  DW  write data
- mem_sel  in  DW/8  byte enables
- mem_rdata  out  DW  load data, valid when mem_ready
- mem_ready  out  1  one-cycle completion pulse for MEM
- bus_req  out  1  bus transaction request
- bus_we  out  1  bus write strobe
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_sel  out  DW/8  bus byte enables
- bus_ack  in  1  bus completion, one cycle
- bus_rdata  in  DW  bus read data, valid with bus_ack
- bus_err  out  1  one-cycle timeout pulse
- stallreq_if  out  1  IF must stall
- stallreq_mem  out  1  MEM must stall

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst=0), asynchronous:
  - FSM to IDLE.
  - All registered outputs to 0: bus_*, if_rdata, mem_rdata, if_ready, mem_ready, bus_err.
  - Any in-flight transaction is abandoned; a late bus_ack after reset is ignored.
- FSM states:
  - IDLE: no grant. mem_req has priority over if_req, because MEM holds the older instruction.
    - mem_req -> GNT_MEM.
    - else if_req -> GNT_IF.
    - else stay in IDLE.
  - GNT_IF / GNT_MEM:
    - bus_req=1, with bus_addr/we/wdata/sel registered from the granted requester on entry.
    - For IF: bus_we=0, bus_sel=all ones.
    - Hold until bus_ack.
    - On bus_ack:
      - Capture bus_rdata into the requester's rdata register (writes capture too; the value is don't-care).
      - Pulse the requester's ready next cycle.
      - Drop bus_req next cycle.
      - Go to IDLE.
- Latency: request first sampled at edge N -> bus_req high after N; bus_ack at edge M -> ready high for cycle M+1. Zero-wait bus gives a 2-cycle transaction.
- Re-grant lockout: in a cycle where x_ready=1, the arbiter does not grant requester x again. A requester drops req in the ready cycle.
  - The other requester may be granted in that same cycle.
  - After a MEM completion with if_req pending, IF is granted next. This prevents IF starvation by back-to-back loads.
- Stall outputs (combinational):
  - stallreq_if = if_req & ~if_ready.
  - stallreq_mem = mem_req & ~mem_ready.
  - Both forced to 0 while rst=0.
- Simultaneous if_req and mem_req in IDLE: MEM wins; IF keeps stalling.
- mem_req raised while IF is in flight: IF completes first; MEM is then granted from IDLE.
- bus_ack while in IDLE: ignored.
- rdata registers hold their value until the next capture.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (width ceil(log2(TIMEOUT+1))) clears on grant and increments each cycle bus_req=1 without bus_ack.
  - When the counter reaches TIMEOUT:
    - The transaction is terminated.
    - The requester's rdata is set to 0 and its ready pulses.
    - bus_err pulses for the same cycle.
    - FSM returns to IDLE.
  - bus_ack in the same cycle as the terminal count takes precedence as a normal completion.
- Undefined: no counter; the arbiter waits for bus_ack indefinitely; bus_err is tied 0.

Test Plan:
- Reset mid-GNT_MEM (rst low at cycle 3 of 5-wait access) -> all outputs 0 immediately, FSM IDLE, late bus_ack ignored, no mem_ready.
- if_req only, addr 0x100, bus_ack 1 cycle after bus_req, bus_rdata 0x00500093 -> bus_addr=0x100, bus_we=0, if_ready one cycle later with if_rdata=0x00500093, stallreq_if high until then.
- Simultaneous if_req (0x104) and mem_req write (0x2000, 0xDEADBEEF, sel 0xF) -> MEM granted first (bus_we=1, wdata 0xDEADBEEF), then IF granted the cycle mem_ready pulses; stallreq_if high throughout.
- Back-to-back mem_req (three loads) with if_req held -> order MEM, IF, MEM, IF...; IF never waits more than one MEM transaction.
- Stray bus_ack in IDLE -> no ready pulse, rdata unchanged.
- ARB_TIMEOUT_EN, TIMEOUT=4, bus_ack never asserted -> after 4 cycles of bus_req, bus_err and mem_ready pulse together, mem_rdata=0, bus_req drops.
